// File: rtl/time_alarm_pkg.sv
// Shared definitions for the time alarm peripheral and other consumers of the system Time count.
package time_alarm_pkg;

  localparam int TIME_W = 16;

  localparam logic ADDR_INTERVAL = 1'b0;
  localparam logic ADDR_CONTROL  = 1'b1;

  localparam int CTRL_ENABLE   = 0;
  localparam int CTRL_PERIODIC = 1;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } alarmState_t;

endpackage

// File: rtl/time_tick_detect.sv
// Flags the cycles on which the system Time count has advanced since the previous cycle.
module time_tick_detect #(
  parameter int W = 16
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic [W-1:0] Time,
  output logic         Tick
);

  logic [W-1:0] timePrev;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      timePrev <= '0;
    end else begin
      timePrev <= Time;
    end
  end

  assign Tick = (Time != timePrev);

endmodule

// File: rtl/time_alarm.sv
// Programmable one-shot/periodic alarm on the system Time count, with a level interrupt,
// acknowledge handshake and saturating overrun counter.
module time_alarm
  import time_alarm_pkg::*;
#(
  parameter int TIME_W = time_alarm_pkg::TIME_W,
  parameter int OVR_W  = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [TIME_W-1:0] Time,
  input  logic              WrEn,
  input  logic              WrAddr,
  input  logic [TIME_W-1:0] WrData,
  input  logic              Ack,
  output logic              Irq,
  output logic              Armed,
  output logic [TIME_W-1:0] Remaining,
  output logic [OVR_W-1:0]  Overruns
);

  alarmState_t       state;
  alarmState_t       stateNext;
  logic [TIME_W-1:0] interval;
  logic [TIME_W-1:0] target;
  logic [TIME_W-1:0] remainingNext;
  logic              periodic;
  logic              irqNext;
  logic              tick;
  logic              wrInterval;
  logic              wrControl;
  logic              armReq;
  logic              expiry;
  logic              overrunInc;

  time_tick_detect #(.W(TIME_W)) tickDetect (
    .Clock (Clock),
    .Reset (Reset),
    .Time  (Time),
    .Tick  (tick)
  );

  // A CONTROL write in the same cycle as an expiry wins and suppresses the expiry entirely.
  assign wrInterval = WrEn && (WrAddr == ADDR_INTERVAL);
  assign wrControl  = WrEn && (WrAddr == ADDR_CONTROL);
  assign armReq     = wrControl && WrData[CTRL_ENABLE];
  assign expiry     = (state == ARMED) && tick && (Time == target) && !wrControl;
  assign overrunInc = expiry && Irq && !Ack && (Overruns != '1);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    if (wrControl) begin
      stateNext = WrData[CTRL_ENABLE] ? ARMED : IDLE;
    end else if (expiry && !periodic) begin
      stateNext = IDLE;
    end
  end

  always_comb begin
    irqNext       = Irq;
    remainingNext = '0;
    if (expiry) begin
      irqNext = 1'b1;
    end else if (Ack) begin
      irqNext = 1'b0;
    end
    if (state == ARMED) begin
      remainingNext = target - Time;
    end
  end

  // Periodic reload adds to the old Target so that late service never accumulates drift.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      interval  <= '0;
      target    <= '0;
      periodic  <= 1'b0;
      Irq       <= 1'b0;
      Remaining <= '0;
      Overruns  <= '0;
    end else begin
      Irq       <= irqNext;
      Remaining <= remainingNext;
      if (wrInterval) begin
        interval <= WrData;
      end
      if (armReq) begin
        target   <= Time + interval;
        periodic <= WrData[CTRL_PERIODIC];
      end else if (expiry && periodic) begin
        target <= target + interval;
      end
      if (armReq) begin
        Overruns <= '0;
      end else if (overrunInc) begin
        Overruns <= Overruns + OVR_W'(1);
      end
    end
  end

  assign Armed = (state == ARMED);

endmodule

// File: tb/tb_time_alarm.sv
// Directed vector bench for time_alarm: table of per-cycle vectors plus hand-written
// sequences for the full-wrap Interval=0 case and reset mid-operation.
module tb_time_alarm;

  logic        Clock;
  logic        Reset;
  logic [15:0] Time;
  logic        WrEn;
  logic        WrAddr;
  logic [15:0] WrData;
  logic        Ack;
  logic        Irq;
  logic        Armed;
  logic [15:0] Remaining;
  logic [7:0]  Overruns;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] tm;
    logic        wrEn;
    logic        wrAddr;
    logic [15:0] wrData;
    logic        ack;
    logic        expIrq;
    logic        expArmed;
    logic [15:0] expRem;
    logic [7:0]  expOvr;
  } vec_t;

  vec_t vecs[$];

  time_alarm #(.TIME_W(16), .OVR_W(8)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Time      (Time),
    .WrEn      (WrEn),
    .WrAddr    (WrAddr),
    .WrData    (WrData),
    .Ack       (Ack),
    .Irq       (Irq),
    .Armed     (Armed),
    .Remaining (Remaining),
    .Overruns  (Overruns)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  function automatic vec_t mk(input logic [15:0] tm, input logic wrEn, input logic wrAddr,
                              input logic [15:0] wrData, input logic ack, input logic expIrq,
                              input logic expArmed, input logic [15:0] expRem, input logic [7:0] expOvr);
    vec_t v;
    v.tm = tm; v.wrEn = wrEn; v.wrAddr = wrAddr; v.wrData = wrData; v.ack = ack;
    v.expIrq = expIrq; v.expArmed = expArmed; v.expRem = expRem; v.expOvr = expOvr;
    return v;
  endfunction

  // Drive one cycle of inputs, then sample #1 after the rising edge that consumed them.
  task automatic applyStimulus(input logic [15:0] tm, input logic wrEn, input logic wrAddr,
                               input logic [15:0] wrData, input logic ack);
    Time   = tm;
    WrEn   = wrEn;
    WrAddr = wrAddr;
    WrData = wrData;
    Ack    = ack;
    @(posedge Clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  initial begin
    int irqSeen;
    int armedLost;

    Reset = 1'b0; Time = 16'h0100; WrEn = 1'b0; WrAddr = 1'b0; WrData = '0; Ack = 1'b0;
    #1;
    checkOutput("reset irq", Irq, 0);
    checkOutput("reset armed", Armed, 0);
    checkOutput("reset remaining", Remaining, 0);
    checkOutput("reset overruns", Overruns, 0);
    @(posedge Clock); @(posedge Clock); #1;
    Reset = 1'b1;

    //               time      we   adr   data    ack  irq  arm  rem       ovr
    // one-shot, Target 0x0105
    vecs.push_back(mk(16'h0100, 1, 0, 16'h0005, 0,   0,   0,   16'h0000, 0));
    vecs.push_back(mk(16'h0100, 1, 1, 16'h0001, 0,   0,   1,   16'h0000, 0));
    vecs.push_back(mk(16'h0101, 0, 0, 16'h0000, 0,   0,   1,   16'h0004, 0));
    vecs.push_back(mk(16'h0102, 0, 0, 16'h0000, 0,   0,   1,   16'h0003, 0));
    vecs.push_back(mk(16'h0103, 0, 0, 16'h0000, 0,   0,   1,   16'h0002, 0));
    vecs.push_back(mk(16'h0104, 0, 0, 16'h0000, 0,   0,   1,   16'h0001, 0));
    vecs.push_back(mk(16'h0105, 0, 0, 16'h0000, 0,   1,   0,   16'h0000, 0));
    vecs.push_back(mk(16'h0106, 0, 0, 16'h0000, 0,   1,   0,   16'h0000, 0));
    vecs.push_back(mk(16'h0106, 0, 0, 16'h0000, 1,   0,   0,   16'h0000, 0));
    vecs.push_back(mk(16'h0107, 0, 0, 16'h0000, 0,   0,   0,   16'h0000, 0));
    // wrap, Target 0x0002
    vecs.push_back(mk(16'hFFFE, 1, 0, 16'h0004, 0,   0,   0,   16'h0000, 0));
    vecs.push_back(mk(16'hFFFE, 1, 1, 16'h0001, 0,   0,   1,   16'h0000, 0));
    vecs.push_back(mk(16'hFFFF, 0, 0, 16'h0000, 0,   0,   1,   16'h0003, 0));
    vecs.push_back(mk(16'h0000, 0, 0, 16'h0000, 0,   0,   1,   16'h0002, 0));
    vecs.push_back(mk(16'h0001, 0, 0, 16'h0000, 0,   0,   1,   16'h0001, 0));
    vecs.push_back(mk(16'h0002, 0, 0, 16'h0000, 0,   1,   0,   16'h0000, 0));
    vecs.push_back(mk(16'h0003, 0, 0, 16'h0000, 1,   0,   0,   16'h0000, 0));
    // periodic overrun, Interval 3 from 0x10
    vecs.push_back(mk(16'h0010, 1, 0, 16'h0003, 0,   0,   0,   16'h0000, 0));
    vecs.push_back(mk(16'h0010, 1, 1, 16'h0003, 0,   0,   1,   16'h0000, 0));
    vecs.push_back(mk(16'h0011, 0, 0, 16'h0000, 0,   0,   1,   16'h0002, 0));
    vecs.push_back(mk(16'h0012, 0, 0, 16'h0000, 0,   0,   1,   16'h0001, 0));
    vecs.push_back(mk(16'h0013, 0, 0, 16'h0000, 0,   1,   1,   16'h0000, 0));
    vecs.push_back(mk(16'h0014, 0, 0, 16'h0000, 0,   1,   1,   16'h0002, 0));
    vecs.push_back(mk(16'h0015, 0, 0, 16'h0000, 0,   1,   1,   16'h0001, 0));
    vecs.push_back(mk(16'h0016, 0, 0, 16'h0000, 0,   1,   1,   16'h0000, 1));
    vecs.push_back(mk(16'h0017, 0, 0, 16'h0000, 0,   1,   1,   16'h0002, 1));
    vecs.push_back(mk(16'h0018, 0, 0, 16'h0000, 0,   1,   1,   16'h0001, 1));
    vecs.push_back(mk(16'h0019, 0, 0, 16'h0000, 0,   1,   1,   16'h0000, 2));
    // Ack colliding with expiry, Interval 2 from 0x20
    vecs.push_back(mk(16'h0020, 1, 0, 16'h0002, 0,   1,   1,   16'hFFFC, 2));
    vecs.push_back(mk(16'h0020, 1, 1, 16'h0003, 0,   1,   1,   16'hFFFC, 0));
    vecs.push_back(mk(16'h0021, 0, 0, 16'h0000, 0,   1,   1,   16'h0001, 0));
    vecs.push_back(mk(16'h0022, 0, 0, 16'h0000, 1,   1,   1,   16'h0000, 0));
    vecs.push_back(mk(16'h0023, 0, 0, 16'h0000, 0,   1,   1,   16'h0001, 0));
    vecs.push_back(mk(16'h0024, 0, 0, 16'h0000, 0,   1,   1,   16'h0000, 1));
    vecs.push_back(mk(16'h0024, 1, 1, 16'h0000, 1,   0,   0,   16'h0002, 1));
    vecs.push_back(mk(16'h0025, 0, 0, 16'h0000, 0,   0,   0,   16'h0000, 1));
    // CONTROL write on the expiry cycle re-arms instead of firing
    vecs.push_back(mk(16'h0030, 1, 0, 16'h0002, 0,   0,   0,   16'h0000, 1));
    vecs.push_back(mk(16'h0030, 1, 1, 16'h0001, 0,   0,   1,   16'h0000, 0));
    vecs.push_back(mk(16'h0031, 0, 0, 16'h0000, 0,   0,   1,   16'h0001, 0));
    vecs.push_back(mk(16'h0032, 1, 1, 16'h0001, 0,   0,   1,   16'h0000, 0));
    vecs.push_back(mk(16'h0033, 0, 0, 16'h0000, 0,   0,   1,   16'h0001, 0));
    vecs.push_back(mk(16'h0034, 0, 0, 16'h0000, 0,   1,   0,   16'h0000, 0));
    vecs.push_back(mk(16'h0035, 0, 0, 16'h0000, 1,   0,   0,   16'h0000, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].tm, vecs[i].wrEn, vecs[i].wrAddr, vecs[i].wrData, vecs[i].ack);
      checkOutput($sformatf("v%0d irq", i), Irq, vecs[i].expIrq);
      checkOutput($sformatf("v%0d armed", i), Armed, vecs[i].expArmed);
      checkOutput($sformatf("v%0d remaining", i), Remaining, vecs[i].expRem);
      checkOutput($sformatf("v%0d overruns", i), Overruns, vecs[i].expOvr);
    end

    // Interval=0 with Time stalled: must wait a full wrap and fire exactly once
    applyStimulus(16'h0040, 1, 0, 16'h0000, 0);
    applyStimulus(16'h0040, 1, 1, 16'h0001, 0);
    checkOutput("stall armed at start", Armed, 1);
    irqSeen = 0;
    repeat (1000) begin
      applyStimulus(16'h0040, 0, 0, 16'h0000, 0);
      if (Irq) irqSeen++;
    end
    checkOutput("stall irq cycles", irqSeen, 0);
    checkOutput("stall still armed", Armed, 1);
    irqSeen = 0;
    armedLost = 0;
    for (int k = 1; k < 65536; k++) begin
      applyStimulus(16'(k + 32'h40), 0, 0, 16'h0000, 0);
      if (Irq) irqSeen++;
      if (!Armed) armedLost++;
    end
    checkOutput("wrap early irq cycles", irqSeen, 0);
    checkOutput("wrap armed lost cycles", armedLost, 0);
    applyStimulus(16'h0040, 0, 0, 16'h0000, 0);
    checkOutput("wrap irq fires", Irq, 1);
    checkOutput("wrap one-shot disarms", Armed, 0);
    applyStimulus(16'h0040, 0, 0, 16'h0000, 1);
    checkOutput("wrap ack clears", Irq, 0);
    irqSeen = 0;
    repeat (20) begin
      applyStimulus(16'h0040, 0, 0, 16'h0000, 0);
      if (Irq) irqSeen++;
    end
    checkOutput("wrap fires once", irqSeen, 0);

    // Reset pulse while armed abandons the pending alarm
    applyStimulus(16'h0050, 1, 0, 16'h0004, 0);
    applyStimulus(16'h0050, 1, 1, 16'h0003, 0);
    applyStimulus(16'h0051, 0, 0, 16'h0000, 0);
    applyStimulus(16'h0052, 0, 0, 16'h0000, 0);
    checkOutput("pre-reset remaining", Remaining, 2);
    checkOutput("pre-reset armed", Armed, 1);
    Reset = 1'b0;
    #1;
    checkOutput("mid reset irq", Irq, 0);
    checkOutput("mid reset armed", Armed, 0);
    checkOutput("mid reset remaining", Remaining, 0);
    @(posedge Clock); #1;
    Reset = 1'b1;
    irqSeen = 0;
    armedLost = 0;
    for (int k = 3; k <= 8; k++) begin
      applyStimulus(16'(k + 32'h50), 0, 0, 16'h0000, 0);
      if (Irq) irqSeen++;
      if (Armed) armedLost++;
    end
    checkOutput("post-reset irq cycles", irqSeen, 0);
    checkOutput("post-reset armed cycles", armedLost, 0);
    checkOutput("post-reset remaining", Remaining, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/time_alarm.md
Name: time_alarm

Overview:
- Consumer end of the system time base. It watches the free-running 16-bit Time count produced by the system clock block and raises an interrupt when a programmed number of ticks has elapsed.
- Supports one-shot and periodic modes, an acknowledge handshake, and overrun counting.
- Sits between the time base and the CPU's memory-mapped peripheral bus.

Parameters:
- TIME_W, 16, width of Time, Interval and Target.
- OVR_W, 8, width of the saturating overrun counter.

Ports:
- Clock  input  1  system clock.
- Reset  input  1  asynchronous, active-low reset.
- Time  input  TIME_W  current system time. Increments by 1 per tick and is registered in the Clock domain.
- WrEn  input  1  single-cycle register write strobe.
- WrAddr  input  1  0 = INTERVAL register, 1 = CONTROL register.
- WrData  input  TIME_W  write data. For CONTROL: bit0 = Enable, bit1 = Periodic.
- Ack  input  1  single-cycle interrupt acknowledge.
- Irq  output  1  interrupt request, level, held until Ack.
- Armed  output  1  high while the state is ARMED.
- Remaining  output  TIME_W  Target - Time (mod 2^TIME_W), registered.
- Overruns  output  OVR_W  count of periodic expiries that occurred while Irq was already high.

Behaviour:
- Reset (async, Reset=0) clears everything:
  - State = IDLE.
  - Irq, Armed, Remaining, Overruns = 0.
  - Interval, Target, Periodic = 0.
  - TimePrev = 0.
  - Reset mid-operation abandons any pending alarm; no Irq is generated afterwards.
- Tick detect: TimePrev <= Time every cycle. Tick = (Time != TimePrev). Expiry is evaluated only on Tick cycles, so a stalled Time never fires twice.
- States: IDLE, ARMED. Irq is an independent flag, not a state.
- Write INTERVAL: Interval <= WrData. Takes effect at the next arm or at the next periodic reload. It does not alter the current Target.
- Write CONTROL with Enable=1 (any state):
  - Target <= Time + Interval (mod 2^TIME_W), using Time sampled that cycle.
  - Periodic <= bit1.
  - State -> ARMED.
  - Re-arming while ARMED restarts the count.
- Write CONTROL with Enable=0: state -> IDLE. Irq is unchanged.
- Interval=0 yields Target=Time. This fires after a full wrap of 2^TIME_W ticks; it never fires immediately.
- Expiry = ARMED && Tick && Time == Target, evaluated at posedge N. Latency: Irq is high after posedge N, i.e. one cycle after Time reaches Target. On expiry:
  - One-shot: state -> IDLE.
  - Periodic: Target <= Target + Interval and stay ARMED. The reload is drift-free and based on Target, not on Time.
  - Irq <= 1.
  - If Irq was already 1 and Ack is not present this cycle: Overruns <= Overruns + 1, saturating at 2^OVR_W - 1.
- Ack: Irq <= 0, unless an expiry occurs in the same cycle. In that case Irq stays 1 (the new event wins) and Overruns does not increment.
- Overruns clears only on reset or on a CONTROL write with Enable=1.
- Simultaneous CONTROL write and expiry: the write wins. Target is recomputed, there is no Irq set, and there is no overrun.
- Remaining <= Target - Time each cycle while ARMED; 0 in IDLE.
- Armed is registered and equal to (state == ARMED).
- Wrap-around: Target arithmetic is modulo 2^TIME_W, and the equality compare handles Time rollover from FFFF to 0000 naturally.

Decomposition:
- Shared package holds:
  - TIME_W.
  - Register address constants ADDR_INTERVAL=0 and ADDR_CONTROL=1.
  - CONTROL bit indices CTRL_ENABLE=0 and CTRL_PERIODIC=1.
  - State encoding IDLE/ARMED.
- One natural sub-module: time_tick_detect. It holds TimePrev and the Tick compare, and is reusable by other Time consumers.
- The remainder is flat.

Test Plan:
- One-shot: Time=0x0100, write INTERVAL=5, then CONTROL=0x1 -> Target=0x0105. Irq rises one cycle after Time=0x0105, Armed drops to 0, Remaining reads 0. Ack -> Irq=0.
- Wrap: Time=0xFFFE, INTERVAL=4, arm one-shot -> Target=0x0002. Irq rises one cycle after Time rolls 0xFFFF -> 0x0000 -> 0x0001 -> 0x0002.
- Periodic with overrun: INTERVAL=3, CONTROL=0x3 at Time=0x10, never Ack -> Irq at Time=0x13. Overruns = 1 at 0x16 and 2 at 0x19. Remains Armed.
- Ack collides with expiry: periodic INTERVAL=2, assert Ack on the expiry cycle at Time=0x22 -> Irq stays 1, Overruns unchanged.
- Stalled Time / Interval=0: hold Time=0x0040 and arm with INTERVAL=0 -> no Irq for 1000 cycles. Then step Time through to 0x0040 after a full wrap -> Irq=1 exactly once.
- Reset mid-operation: armed with Remaining=2, pulse Reset low for one cycle -> all outputs 0. No Irq when Time later reaches the old Target.
